// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipelined logic unit.
// Stage 1 registers the bitwise function of the operands, stage 2 applies
// the optional reduction and registers the result with zero/all-ones flags.
// Define LOGIC_UNIT_CNT_EN to enable the saturating accepted-transaction
// counter on op_count; otherwise op_count is tied to zero.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NOTB = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } opSel_t;

  typedef enum logic [1:0] {
    MODE_BIT  = 2'd0,
    MODE_RAND = 2'd1,
    MODE_ROR  = 2'd2,
    MODE_RXOR = 2'd3
  } modeSel_t;

  logic             r_s1Valid;
  logic [WIDTH-1:0] r_s1Data;
  logic [1:0]       r_s1Mode;
  logic             r_s2Valid;
  logic [WIDTH-1:0] r_s2Result;
  logic             r_s2Zero;
  logic             r_s2Ones;

  logic             w_s1Advance;
  logic [WIDTH-1:0] w_bitwise;
  logic [WIDTH-1:0] w_reduced;
  logic             w_zero;
  logic             w_ones;

  // s1 may move forward when s2 is empty or being drained this cycle;
  // this depends only on registered state and out_ready, never on in_valid.
  assign w_s1Advance = !r_s2Valid || out_ready;
  assign in_ready    = !r_s1Valid || w_s1Advance;

  assign out_valid  = r_s2Valid;
  assign out_result = r_s2Result;
  assign out_zero   = r_s2Zero;
  assign out_ones   = r_s2Ones;

  // Opcode-selected bitwise function of the incoming operands.
  always_comb begin
    w_bitwise = '0;
    case (opSel_t'(in_op))
      OP_AND:  w_bitwise = in_a & in_b;
      OP_OR:   w_bitwise = in_a | in_b;
      OP_NOTA: w_bitwise = ~in_a;
      OP_NOTB: w_bitwise = ~in_b;
      OP_NAND: w_bitwise = ~(in_a & in_b);
      OP_NOR:  w_bitwise = ~(in_a | in_b);
      OP_XOR:  w_bitwise = in_a ^ in_b;
      OP_XNOR: w_bitwise = ~(in_a ^ in_b);
      default: w_bitwise = '0;
    endcase
  end

  // Optional reduction of the stage-1 word to a single bit in the LSB.
  always_comb begin
    w_reduced = '0;
    case (modeSel_t'(r_s1Mode))
      MODE_BIT:  w_reduced    = r_s1Data;
      MODE_RAND: w_reduced[0] = &r_s1Data;
      MODE_ROR:  w_reduced[0] = |r_s1Data;
      MODE_RXOR: w_reduced[0] = ^r_s1Data;
      default:   w_reduced    = r_s1Data;
    endcase
  end

  assign w_zero = (w_reduced == '0);
  assign w_ones = &w_reduced;

  // Stage 1: capture a new transaction whenever the stage can accept one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Mode  <= '0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Data <= w_bitwise;
        r_s1Mode <= in_mode;
      end
    end
  end

  // Stage 2: load from s1 on advance; an empty s1 only clears the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid  <= 1'b0;
      r_s2Result <= '0;
      r_s2Zero   <= 1'b0;
      r_s2Ones   <= 1'b0;
    end else if (w_s1Advance) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Result <= w_reduced;
        r_s2Zero   <= w_zero;
        r_s2Ones   <= w_ones;
      end
    end
  end

`ifdef LOGIC_UNIT_CNT_EN
  logic [CNT_W-1:0] r_opCount;
  logic             w_accept;

  assign w_accept = in_valid && in_ready;
  assign op_count = r_opCount;

  // Saturating count of accepted transactions, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opCount <= '0;
    end else if (w_accept && (r_opCount != {CNT_W{1'b1}})) begin
      r_opCount <= r_opCount + CNT_W'(1);
    end
  end
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: self-checking bench for logic_unit_pipe (WIDTH=8,
// CNT_W=4). A queue-based reference model tracks accepted transactions and
// their expected results; a single negedge compare process checks every
// output each cycle, and directed sequences pin known literal results.
module tb_logic_unit_pipe;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_op;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_zero;
  logic          out_ones;
  logic [CW-1:0] op_count;

  typedef struct {
    logic [W-1:0] res;
    int           cycle;
  } modelEnt_t;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ones;
    int           lat;
    int           popCycle;
  } logEnt_t;

  modelEnt_t model[$];
  logEnt_t   dutLog[$];
  int        total = 0;
  int        bad = 0;
  int        cycleNow = 0;
  int        acceptCount = 0;
  logic      randReady = 1'b0;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_op(in_op),
    .in_mode(in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_zero(out_zero),
    .out_ones(out_ones),
    .op_count(op_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output word for one transaction, straight from the opcode table.
  function automatic logic [W-1:0] modelResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op, input logic [1:0] mode);
    logic [W-1:0] r;
    r = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~a;
      3'd3: r = ~b;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    case (mode)
      2'd0: return r;
      2'd1: return (r == {W{1'b1}}) ? W'(1) : W'(0);
      2'd2: return (r != '0) ? W'(1) : W'(0);
      default: return W'($countones(r) % 2);
    endcase
  endfunction

  // Expected op_count given the number of accepts since reset.
  function automatic logic [CW-1:0] modelCount(input int n);
`ifdef LOGIC_UNIT_CNT_EN
    return (n >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(n);
`else
    return (n > 0) ? CW'(0) : CW'(0);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycleNow);
    end
  endtask

  // Present one transaction and hold it until it is accepted.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic [1:0] mode);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_mode = mode;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until the output log holds at least n entries.
  task automatic waitLog(input int n);
    int k;
    k = 0;
    while (dutLog.size() < n && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (dutLog.size() < n) begin
      checkOutput("result_timeout", 64'(dutLog.size()), 64'(n));
    end
  endtask

  // Compare process: every cycle check outputs against the model, then
  // retire drained results and enqueue newly accepted transactions.
  initial begin
    logic expValid;
    forever begin
      @(negedge clk);
      cycleNow++;
      if (!rst_n) begin
        model.delete();
        acceptCount = 0;
        continue;
      end
      expValid = 1'b0;
      if (model.size() > 0) begin
        expValid = (cycleNow - model[0].cycle) >= 2;
      end
      checkOutput("out_valid", 64'(out_valid), 64'(expValid));
      if (expValid && out_valid) begin
        checkOutput("out_result", 64'(out_result), 64'(model[0].res));
        checkOutput("out_zero", 64'(out_zero), 64'(model[0].res == '0));
        checkOutput("out_ones", 64'(out_ones), 64'(model[0].res == {W{1'b1}}));
      end
      checkOutput("in_ready", 64'(in_ready), 64'((model.size() < 2) || out_ready));
      checkOutput("op_count", 64'(op_count), 64'(modelCount(acceptCount)));
      if (out_valid && out_ready && model.size() > 0) begin
        dutLog.push_back('{res: out_result, zero: out_zero, ones: out_ones,
                           lat: cycleNow - model[0].cycle, popCycle: cycleNow});
        void'(model.pop_front());
      end
      if (in_valid && in_ready) begin
        model.push_back('{res: modelResult(in_a, in_b, in_op, in_mode), cycle: cycleNow});
        acceptCount++;
      end
    end
  end

  // Random backpressure generator used during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences followed by a randomized phase.
  initial begin
    logic [W-1:0] sweepExp[8];
    logic [W-1:0] bpExp[5];
    logic [W-1:0] bpA;
    logic [W-1:0] bpB;
    logic [2:0]   bpOps[5];
    int           base;
    int           startAcc;
    int           k;

    sweepExp = '{8'h05, 8'hAF, 8'h5A, 8'hF0, 8'hFA, 8'h50, 8'hAA, 8'h55};
    bpExp    = '{8'h18, 8'h7E, 8'h66, 8'hE7, 8'h81};
    bpOps    = '{3'd0, 3'd1, 3'd6, 3'd4, 3'd5};
    bpA      = 8'h3C;
    bpB      = 8'h5A;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    in_mode = '0;
    out_ready = 1'b1;
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_result", 64'(out_result), 64'd0);
    checkOutput("rst_out_zero", 64'(out_zero), 64'd0);
    checkOutput("rst_out_ones", 64'(out_ones), 64'd0);
    checkOutput("rst_op_count", 64'(op_count), 64'd0);
    #10;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Single XOR operation, latency 2.
    @(posedge clk);
    #1;
    base = dutLog.size();
    applyStimulus(8'hF0, 8'h3C, 3'd6, 2'd0);
    waitLog(base + 1);
    checkOutput("single_result", 64'(dutLog[base].res), 64'hCC);
    checkOutput("single_zero", 64'(dutLog[base].zero), 64'd0);
    checkOutput("single_ones", 64'(dutLog[base].ones), 64'd0);
    checkOutput("single_latency", 64'(dutLog[base].lat), 64'd2);

    // Full opcode sweep, back-to-back.
    @(posedge clk);
    #1;
    base = dutLog.size();
    for (int i = 0; i < 8; i++) applyStimulus(8'hA5, 8'h0F, 3'(i), 2'd0);
    waitLog(base + 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("sweep_result_%0d", i), 64'(dutLog[base + i].res), 64'(sweepExp[i]));
      checkOutput($sformatf("sweep_latency_%0d", i), 64'(dutLog[base + i].lat), 64'd2);
      if (i > 0) begin
        checkOutput($sformatf("sweep_spacing_%0d", i),
                    64'(dutLog[base + i].popCycle - dutLog[base + i - 1].popCycle), 64'd1);
      end
    end

    // Reduction modes.
    @(posedge clk);
    #1;
    base = dutLog.size();
    applyStimulus(8'hFF, 8'hFF, 3'd0, 2'd1);
    applyStimulus(8'hFF, 8'hFF, 3'd6, 2'd2);
    applyStimulus(8'h07, 8'h00, 3'd1, 2'd3);
    waitLog(base + 3);
    checkOutput("red_and_result", 64'(dutLog[base].res), 64'h01);
    checkOutput("red_and_ones", 64'(dutLog[base].ones), 64'd0);
    checkOutput("red_or_result", 64'(dutLog[base + 1].res), 64'h00);
    checkOutput("red_or_zero", 64'(dutLog[base + 1].zero), 64'd1);
    checkOutput("red_xor_result", 64'(dutLog[base + 2].res), 64'h01);

    // Backpressure: 5 ops with out_ready low for 4 cycles.
    @(posedge clk);
    #1;
    base = dutLog.size();
    startAcc = acceptCount;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) applyStimulus(bpA, bpB, bpOps[i], 2'd0);
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        checkOutput("bp_accepts", 64'(acceptCount - startAcc), 64'd2);
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitLog(base + 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_result_%0d", i), 64'(dutLog[base + i].res), 64'(bpExp[i]));
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput("bp_no_extra", 64'(dutLog.size()), 64'(base + 5));
`ifdef LOGIC_UNIT_CNT_EN
    checkOutput("count_saturated", 64'(op_count), 64'hF);
`else
    checkOutput("count_disabled", 64'(op_count), 64'h0);
`endif

    // Asynchronous reset with both stages full.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(8'h11, 8'h22, 3'd1, 2'd0);
    applyStimulus(8'h44, 8'h88, 3'd1, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_result", 64'(out_result), 64'd0);
    checkOutput("midrst_out_zero", 64'(out_zero), 64'd0);
    checkOutput("midrst_out_ones", 64'(out_ones), 64'd0);
    checkOutput("midrst_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    base = dutLog.size();
    applyStimulus(8'h0F, 8'hFF, 3'd4, 2'd0);
    waitLog(base + 1);
    checkOutput("postrst_result", 64'(dutLog[base].res), 64'hF0);
    checkOutput("postrst_latency", 64'(dutLog[base].lat), 64'd2);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("postrst_no_stale", 64'(dutLog.size()), 64'(base + 1));

    // Randomized traffic with random backpressure and idle gaps.
    @(posedge clk);
    #1;
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(W'($urandom), W'($urandom), 3'($urandom), 2'($urandom));
    end
    @(posedge clk);
    #1;
    randReady = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (model.size() > 0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("drain_empty", 64'(model.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
